// File: rtl/rvs_line_memory_pkg.sv
// rtl/rvs_line_memory_pkg.sv - shared types and geometry helpers for the RVS192 line memory
package rvs_line_memory_pkg;

   // Per-channel access sequencing
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } mem_ch_state_e;

   // Bits in one cache line
   function automatic int line_width(input int word_width, input int line_words);
      return word_width * line_words;
   endfunction

   // One byte enable per byte of the line
   function automatic int be_width(input int word_width, input int line_words);
      return (word_width * line_words) / 8;
   endfunction

   // Byte-offset bits inside a line
   function automatic int off_bits(input int word_width, input int line_words);
      return $clog2((word_width * line_words) / 8);
   endfunction

   // Bits needed to index the line array (at least one)
   function automatic int line_idx_bits(input int mem_lines);
      return (mem_lines > 1) ? $clog2(mem_lines) : 1;
   endfunction

endpackage

// File: rtl/rvs_mem_channel_ctrl.sv
// rtl/rvs_mem_channel_ctrl.sv - request edge detection and latency sequencing for one memory channel
module rvs_mem_channel_ctrl
   import rvs_line_memory_pkg::*;
#(
   parameter int RD_LATENCY = 2,
   parameter int WR_LATENCY = 2
) (
   input  logic mem_clk,
   input  logic rst_n,
   input  logic read_req,
   input  logic write_req,
   output logic capture,
   output logic access,
   output logic access_write,
   output logic res
);

   localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   mem_ch_state_e    state;
   logic [CNT_W-1:0] cnt;
   logic             read_q;
   logic             write_q;
   logic             start_read;
   logic             start_write;

   // Rising edges only; a write wins when both rise together
   assign start_read  = read_req && !read_q;
   assign start_write = write_req && !write_q;
   assign capture     = (state == IDLE) && (start_read || start_write);
   assign access      = (state == ACCESS);

   // Request history, latency counter and channel FSM
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         access_write <= 1'b0;
         res          <= 1'b0;
      end else begin
         read_q  <= read_req;
         write_q <= write_req;
         res     <= 1'b0;
         case (state)
            IDLE: begin
               if (start_write) begin
                  state        <= WAIT;
                  cnt          <= CNT_W'(WR_LATENCY - 1);
                  access_write <= 1'b1;
               end else if (start_read) begin
                  state        <= WAIT;
                  cnt          <= CNT_W'(RD_LATENCY - 1);
                  access_write <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= ACCESS;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACCESS: begin
               state <= RESP;
               res   <= 1'b1;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/rvs_line_memory.sv
// rtl/rvs_line_memory.sv - dual-channel line-granular backing memory behind the RVS192 L2
module rvs_line_memory
   import rvs_line_memory_pkg::*;
#(
   parameter int    WORD_WIDTH = 32,
   parameter int    LINE_WORDS = 4,
   parameter int    ADDR_WIDTH = 32,
   parameter int    MEM_LINES  = 512,
   parameter int    RD_LATENCY = 2,
   parameter int    WR_LATENCY = 2,
   parameter string INST_FILE  = "",
   parameter string DATA_FILE  = ""
) (
   input  logic                                mem_clk,
   input  logic                                rst_n,
   input  logic                                inst_read_req,
   input  logic [ADDR_WIDTH-1:0]               inst_addr,
   output logic [LINE_WORDS*WORD_WIDTH-1:0]    inst_mem_read,
   output logic                                inst_res,
   output logic                                inst_err,
   input  logic                                data_read_req,
   input  logic                                data_write_req,
   input  logic [ADDR_WIDTH-1:0]               data_addr,
   input  logic [LINE_WORDS*WORD_WIDTH-1:0]    data_mem_write,
   input  logic [LINE_WORDS*WORD_WIDTH/8-1:0]  data_byte_en,
   output logic [LINE_WORDS*WORD_WIDTH-1:0]    data_mem_read,
   output logic                                data_res,
   output logic                                data_err
);

   localparam int LW = line_width(WORD_WIDTH, LINE_WORDS);
   localparam int BW = be_width(WORD_WIDTH, LINE_WORDS);
   localparam int OB = off_bits(WORD_WIDTH, LINE_WORDS);
   localparam int LB = ADDR_WIDTH - OB;
   localparam int IB = line_idx_bits(MEM_LINES);

   logic [LW-1:0] mem [MEM_LINES];

   logic          i_capture, i_access, i_access_write;
   logic          d_capture, d_access, d_access_write;
   logic          i_err_q, d_err_q;
   logic [IB-1:0] i_idx_q, d_idx_q;
   logic [LW-1:0] d_wdata_q;
   logic [BW-1:0] d_be_q;
   logic [LW-1:0] d_merged;
   logic          d_commit;
   logic          collide;

   // Misaligned or beyond-array addresses are rejected without touching the array
   function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
      logic [LB:0] ln;
      ln = {1'b0, a[ADDR_WIDTH-1:OB]};
      return (a[OB-1:0] != '0) || (ln >= (LB+1)'(MEM_LINES));
   endfunction

   function automatic logic [IB-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[OB +: IB];
   endfunction

   rvs_mem_channel_ctrl #(
      .RD_LATENCY (RD_LATENCY),
      .WR_LATENCY (RD_LATENCY)
   ) u_inst_ctrl (
      .mem_clk      (mem_clk),
      .rst_n        (rst_n),
      .read_req     (inst_read_req),
      .write_req    (1'b0),
      .capture      (i_capture),
      .access       (i_access),
      .access_write (i_access_write),
      .res          (inst_res)
   );

   rvs_mem_channel_ctrl #(
      .RD_LATENCY (RD_LATENCY),
      .WR_LATENCY (WR_LATENCY)
   ) u_data_ctrl (
      .mem_clk      (mem_clk),
      .rst_n        (rst_n),
      .read_req     (data_read_req),
      .write_req    (data_write_req),
      .capture      (d_capture),
      .access       (d_access),
      .access_write (d_access_write),
      .res          (data_res)
   );

   // Request operands are frozen at start so the requester may change them afterwards
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         i_err_q   <= 1'b0;
         i_idx_q   <= '0;
         d_err_q   <= 1'b0;
         d_idx_q   <= '0;
         d_wdata_q <= '0;
         d_be_q    <= '0;
      end else begin
         if (i_capture) begin
            i_err_q <= addr_bad(inst_addr);
            i_idx_q <= addr_idx(inst_addr);
         end
         if (d_capture) begin
            d_err_q   <= addr_bad(data_addr);
            d_idx_q   <= addr_idx(data_addr);
            d_wdata_q <= data_mem_write;
            d_be_q    <= data_byte_en;
         end
      end
   end

   // Byte-merge of the captured write line over the stored line
   always_comb begin
      d_merged = mem[d_idx_q];
      for (int b = 0; b < BW; b++) begin
         if (d_be_q[b]) begin
            d_merged[b*8 +: 8] = d_wdata_q[b*8 +: 8];
         end
      end
   end

   assign d_commit = d_access && d_access_write && !d_err_q;
   assign collide  = d_commit && (i_idx_q == d_idx_q);

   // Array write port; contents survive reset
   always_ff @(posedge mem_clk) begin
      if (d_commit) begin
         mem[d_idx_q] <= d_merged;
      end
   end

   // Output registers load on ACCESS and hold until the channel's next ACCESS
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_mem_read <= '0;
         inst_err      <= 1'b0;
         data_mem_read <= '0;
         data_err      <= 1'b0;
      end else begin
         inst_err <= 1'b0;
         data_err <= 1'b0;
         if (i_access && !i_access_write) begin
            inst_err      <= i_err_q;
            inst_mem_read <= i_err_q ? '0 : (collide ? d_merged : mem[i_idx_q]);
         end
         if (d_access) begin
            data_err      <= d_err_q;
            data_mem_read <= d_err_q ? '0 : (d_access_write ? d_merged : mem[d_idx_q]);
         end
      end
   end

endmodule

// File: tb/tb_rvs_line_memory.sv
// tb/tb_rvs_line_memory.sv - directed self-checking bench for rvs_line_memory
module tb_rvs_line_memory;

   logic         mem_clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         inst_read_req = 1'b0;
   logic [31:0]  inst_addr = '0;
   logic [127:0] inst_mem_read;
   logic         inst_res;
   logic         inst_err;
   logic         data_read_req = 1'b0;
   logic         data_write_req = 1'b0;
   logic [31:0]  data_addr = '0;
   logic [127:0] data_mem_write = '0;
   logic [15:0]  data_byte_en = '0;
   logic [127:0] data_mem_read;
   logic         data_res;
   logic         data_err;

   int total = 0;
   int passed = 0;

   localparam logic [127:0] LINE5    = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] ALL11    = 128'h11111111_11111111_11111111_11111111;
   localparam logic [127:0] WR_BEEF  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_DEADBEEF;
   localparam logic [127:0] MRG_BEEF = 128'h11111111_11111111_11111111_DEADBEEF;
   localparam logic [127:0] SIM_LINE = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [127:0] WR_CAFE  = 128'h00000000_00000000_CAFEF00D_00000000;
   localparam logic [127:0] MRG_CAFE = 128'h44444444_33333333_CAFEF00D_11111111;
   localparam logic [127:0] WR_55    = 128'h55555555_00000000_00000000_00000000;
   localparam logic [127:0] MRG_55   = 128'h55555555_11111111_11111111_DEADBEEF;

   rvs_line_memory dut (
      .mem_clk        (mem_clk),
      .rst_n          (rst_n),
      .inst_read_req  (inst_read_req),
      .inst_addr      (inst_addr),
      .inst_mem_read  (inst_mem_read),
      .inst_res       (inst_res),
      .inst_err       (inst_err),
      .data_read_req  (data_read_req),
      .data_write_req (data_write_req),
      .data_addr      (data_addr),
      .data_mem_write (data_mem_write),
      .data_byte_en   (data_byte_en),
      .data_mem_read  (data_mem_read),
      .data_res       (data_res),
      .data_err       (data_err)
   );

   always #5 mem_clk = ~mem_clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Raise one data request, wait for its response, verify latency, payload and pulse width
   task automatic data_op(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [127:0] wdata, input logic [15:0] be,
                          input logic [127:0] exp_data, input logic exp_err);
      int n;
      @(negedge mem_clk);
      data_addr = addr;
      data_mem_write = wdata;
      data_byte_en = be;
      if (wr) data_write_req = 1'b1;
      else    data_read_req = 1'b1;
      n = 0;
      do begin
         @(negedge mem_clk);
         n++;
      end while (!data_res && n < 20);
      check({tag, "_lat"}, 128'(n), 128'(4));
      check({tag, "_data"}, data_mem_read, exp_data);
      check({tag, "_err"}, 128'(data_err), 128'(exp_err));
      @(negedge mem_clk);
      check({tag, "_pulse"}, 128'(data_res), 128'(0));
      data_write_req = 1'b0;
      data_read_req = 1'b0;
   endtask

   task automatic inst_op(input string tag, input logic [31:0] addr,
                          input logic [127:0] exp_data, input logic exp_err);
      int n;
      @(negedge mem_clk);
      inst_addr = addr;
      inst_read_req = 1'b1;
      n = 0;
      do begin
         @(negedge mem_clk);
         n++;
      end while (!inst_res && n < 20);
      check({tag, "_lat"}, 128'(n), 128'(4));
      check({tag, "_data"}, inst_mem_read, exp_data);
      check({tag, "_err"}, 128'(inst_err), 128'(exp_err));
      @(negedge mem_clk);
      check({tag, "_pulse"}, 128'(inst_res), 128'(0));
      inst_read_req = 1'b0;
   endtask

   initial begin
      int n_i, n_d;
      logic [127:0] seen_i, seen_d;

      // Reset state
      repeat (3) @(negedge mem_clk);
      check("rst_inst_res", 128'(inst_res), 128'(0));
      check("rst_inst_err", 128'(inst_err), 128'(0));
      check("rst_inst_data", inst_mem_read, 128'(0));
      check("rst_data_res", 128'(data_res), 128'(0));
      check("rst_data_err", 128'(data_err), 128'(0));
      check("rst_data_data", data_mem_read, 128'(0));
      rst_n = 1'b1;

      // Preload line 5 and read it on the instruction channel
      data_op("pre5", 1'b1, 32'h50, LINE5, 16'hFFFF, LINE5, 1'b0);
      inst_op("iread5", 32'h50, LINE5, 1'b0);

      // Partial write over an all-0x11 line
      data_op("pre2", 1'b1, 32'h20, ALL11, 16'hFFFF, ALL11, 1'b0);
      data_op("wr_be", 1'b1, 32'h20, WR_BEEF, 16'h000F, MRG_BEEF, 1'b0);
      data_op("rd_be", 1'b0, 32'h20, '0, '0, MRG_BEEF, 1'b0);
      data_op("wr_be0", 1'b1, 32'h20, '1, 16'h0000, MRG_BEEF, 1'b0);

      // Error responses leave the array untouched
      inst_op("ierr_mis", 32'h54, '0, 1'b1);
      data_op("derr_rng", 1'b0, 32'h2000, '0, '0, '0, 1'b1);
      data_op("derr_wmis", 1'b1, 32'h24, '1, 16'hFFFF, '0, 1'b1);
      data_op("derr_wrng", 1'b1, 32'h2000, '1, 16'hFFFF, '0, 1'b1);
      data_op("rd_after_err", 1'b0, 32'h20, '0, '0, MRG_BEEF, 1'b0);
      inst_op("iread5_again", 32'h50, LINE5, 1'b0);

      // Simultaneous read and write edges: write only, single response
      @(negedge mem_clk);
      data_addr = 32'h30;
      data_mem_write = SIM_LINE;
      data_byte_en = 16'hFFFF;
      data_read_req = 1'b1;
      data_write_req = 1'b1;
      n_d = 0;
      seen_d = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge mem_clk);
         if (data_res) begin
            n_d++;
            seen_d = data_mem_read;
         end
      end
      check("sim_res_count", 128'(n_d), 128'(1));
      check("sim_echo", seen_d, SIM_LINE);
      data_read_req = 1'b0;
      data_write_req = 1'b0;
      data_op("sim_reread", 1'b0, 32'h30, '0, '0, SIM_LINE, 1'b0);

      // Same-line write and instruction read complete together; re-edge in WAIT ignored
      @(negedge mem_clk);
      data_addr = 32'h50;
      data_mem_write = WR_CAFE;
      data_byte_en = 16'h00F0;
      data_write_req = 1'b1;
      inst_addr = 32'h50;
      inst_read_req = 1'b1;
      n_i = 0;
      n_d = 0;
      seen_i = '0;
      seen_d = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge mem_clk);
         if (c == 1) inst_read_req = 1'b0;
         if (c == 2) inst_read_req = 1'b1;
         if (inst_res) begin
            n_i++;
            seen_i = inst_mem_read;
         end
         if (data_res) begin
            n_d++;
            seen_d = data_mem_read;
         end
      end
      check("col_inst_count", 128'(n_i), 128'(1));
      check("col_data_count", 128'(n_d), 128'(1));
      check("col_inst_data", seen_i, MRG_CAFE);
      check("col_data_echo", seen_d, MRG_CAFE);
      inst_read_req = 1'b0;
      data_write_req = 1'b0;

      // Reset during the WAIT of a write aborts it
      @(negedge mem_clk);
      data_addr = 32'h20;
      data_mem_write = '0;
      data_byte_en = 16'hFFFF;
      data_write_req = 1'b1;
      @(negedge mem_clk);
      rst_n = 1'b0;
      data_write_req = 1'b0;
      @(negedge mem_clk);
      check("abort_out_clear", data_mem_read, 128'(0));
      rst_n = 1'b1;
      n_d = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge mem_clk);
         if (data_res) n_d++;
      end
      check("abort_no_res", 128'(n_d), 128'(0));
      data_op("abort_line_kept", 1'b0, 32'h20, '0, '0, MRG_BEEF, 1'b0);
      data_op("post_rst_wr", 1'b1, 32'h20, WR_55, 16'hF000, MRG_55, 1'b0);
      inst_op("post_rst_iread", 32'h20, MRG_55, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Hard stop so a stuck run still terminates
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rvs_line_memory.md
Name: rvs_line_memory

Overview:
- Parametrised next-generation backing memory behind the RVS192 L2 cache.
- Serves two independent channels: instruction line read, and data line read/write.
- Transfers whole cache lines, with configurable access latency, per-byte write enables and an error response.
- Each channel has a registered edge-sampled request/response handshake and its own latency FSM.

Parameters:
- WORD_WIDTH, 32, bits per word.
- LINE_WORDS, 4, words per line (power of 2, ≥1).
- ADDR_WIDTH, 32, byte-address width.
- MEM_LINES, 512, lines in the array.
- RD_LATENCY, 2, wait cycles for a read (≥1).
- WR_LATENCY, 2, wait cycles for a write (≥1).

Ports:
- mem_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_read_req  in  1  instruction read request (rising edge starts access).
- inst_addr  in  ADDR_WIDTH  instruction line byte address.
- inst_mem_read  out  LINE_WORDS*WORD_WIDTH  instruction line data.
- inst_res  out  1  one-cycle response pulse.
- inst_err  out  1  error qualifier, valid with inst_res.
- data_read_req  in  1  data read request (rising edge).
- data_write_req  in  1  data write request (rising edge).
- data_addr  in  ADDR_WIDTH  data line byte address.
- data_mem_write  in  LINE_WORDS*WORD_WIDTH  write line.
- data_byte_en  in  LINE_WORDS*WORD_WIDTH/8  per-byte write enable.
- data_mem_read  out  LINE_WORDS*WORD_WIDTH  data line read / write echo.
- data_res  out  1  one-cycle response pulse.
- data_err  out  1  error qualifier, valid with data_res.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, FSMs to IDLE, request history flops 0.
  - Array contents are not reset.
  - Reset mid-access aborts the access: no partial write, no response.
- Request sampling:
  - Each request input is registered every cycle.
  - start = req && !req_q, evaluated at a posedge while the channel is IDLE.
  - At start, address (plus write line and byte enables for data) are captured.
  - Edges arriving while the channel is not IDLE are ignored, not queued.
- Data channel simultaneous start: if read and write both rise in the same cycle, the write is serviced and the read edge is dropped. The requester must lower and re-raise the read request.
- Address decode:
  - off = addr[log2(LINE_WORDS*WORD_WIDTH/8)-1:0]; line = next higher bits.
  - Error if off != 0 or line >= MEM_LINES.
  - On error: no array access, response after normal latency, err=1, read data output = 0.
- FSM per channel:
  - IDLE -start-> WAIT (counter loaded with LAT-1).
  - WAIT decrements; at 0 -> ACCESS.
  - ACCESS performs the array read/write and loads the output register -> RESP.
  - RESP drives res=1 (plus err) for exactly one cycle -> IDLE.
- Latency: start sampled at edge T0 gives res high during the cycle after edge T0+LAT+1.
- Output data holding:
  - Output data is held until the next ACCESS of that channel.
  - A new start is accepted at the first edge where the channel is IDLE (edge after RESP).
- Write:
  - Bytes with byte_en=1 are updated; others keep old values.
  - data_mem_read returns the merged post-write line.
  - byte_en all-zero is legal: no change, normal response.
- Collision: when data write ACCESS and inst read ACCESS occur in the same cycle on the same line, inst_mem_read returns the post-write line (write-first).
- Simulation preload: under SIMULATE, $readmemh from parameter file names INST_FILE/DATA_FILE fills line ranges; not synthesised.

Decomposition:
- RVS192_package gains:
  - mem_ch_state_e {IDLE, WAIT, ACCESS, RESP}.
  - LINE_WIDTH, BE_WIDTH, OFF_BITS and LINE_IDX_BITS derivations as localparam functions.
- Sub-module rvs_mem_channel_ctrl holds request history, start detection, latency counter and FSM. Outputs: access strobe, res, captured-address enable.
- Instantiated twice (instruction with RD_LATENCY; data with RD or WR latency selected at start).
- The array and write-merge logic live in the top.

Test Plan:
- RD_LATENCY=2: preload line 5 with 0x44..0x11 pattern; raise inst_read_req with inst_addr=0x50 at edge 0 → inst_res pulses after edge 3 with line 5 data, inst_err=0.
- Data write to 0x20, byte_en=0x000F, data 0xAAAA.._DEADBEEF over an all-0x11 line → only word0 becomes 0xDEADBEEF; data_mem_read echoes the merged line; a subsequent read returns the same.
- inst_addr=0x54 (misaligned) and data_addr=MEM_LINES*16 → res with err=1, read data 0, array unchanged.
- data_read_req and data_write_req rise together → exactly one data_res, write committed; the read re-issued later returns the new data.
- Data write and inst read on the same line completing in the same cycle → inst_mem_read shows the new data; second edge during WAIT ignored (single res).
- rst_n asserted during a data write WAIT → no res, line unchanged after reset release; a new request afterwards completes normally.
